gbc_oam_dma_controller: RTL

- Sequences the GBC OAM DMA. A CPU write to $FF46 starts a 160-byte copy from source page XX00–XX9F to OAM FE00–FE9F.
- Reads the source over a Wishbone-style read initiator port, which the memory bus routes to cartridge, VRAM or WRAM.
- Writes OAM through a direct write strobe.
- Raises cpu_block while active, so the memory bus holds off CPU accesses outside HRAM.

---
 rtl/gbc_oam_dma_controller.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gbc_oam_dma_controller.sv
// GBC OAM DMA sequencer: copies LENGTH bytes from {page, index} to OAM,
// one byte per M-cycle tick, reading over a Wishbone-style initiator port.
module gbc_oam_dma_controller #(
    parameter int LENGTH      = 160,
    parameter int START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_tick,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic        busy,
    output logic        cpu_block,
    output logic        rd_cyc,
    output logic        rd_stb,
    output logic [15:0] rd_addr,
    input  logic        rd_stall,
    input  logic        rd_ack,
    input  logic [7:0]  rd_dat,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_dat
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [7:0] LAST_INDEX  = 8'(LENGTH - 1);
    localparam logic [7:0] DELAY_TICKS = 8'(START_DELAY);

    // Pages $E0-$FF echo WRAM at $C0-$DF.
    function automatic logic [7:0] map_page(input logic [7:0] page);
        logic [7:0] mapped;
        if (page >= 8'hE0) begin
            mapped = page - 8'h20;
        end else begin
            mapped = page;
        end
        return mapped;
    endfunction

    state_t      state_r, state_nx_s;
    logic [7:0]  index_r, index_nx_s;
    logic [7:0]  page_r, page_nx_s;
    logic [7:0]  delay_r, delay_nx_s, delay_step_s;
    logic        drain_r, drain_nx_s;
    logic        busy_r, busy_nx_s;
    logic        cyc_r, cyc_nx_s;
    logic        stb_r, stb_nx_s;
    logic [15:0] addr_r, addr_nx_s;
    logic        we_r, we_nx_s;
    logic [7:0]  oam_addr_r, oam_addr_nx_s;
    logic [7:0]  oam_dat_r, oam_dat_nx_s;
    logic        ack_ok_s;

    // An ack only counts once the request has been (or is being) accepted.
    assign ack_ok_s = cyc_r & rd_ack & (~stb_r | ~rd_stall);

    // Next-state, datapath and bus handshake decisions.
    always_comb begin
        state_nx_s    = state_r;
        index_nx_s    = index_r;
        page_nx_s     = page_r;
        delay_nx_s    = delay_r;
        delay_step_s  = delay_r;
        drain_nx_s    = drain_r;
        busy_nx_s     = busy_r;
        cyc_nx_s      = cyc_r;
        stb_nx_s      = stb_r;
        addr_nx_s     = addr_r;
        we_nx_s       = 1'b0;
        oam_addr_nx_s = oam_addr_r;
        oam_dat_nx_s  = oam_dat_r;

        if (start) begin
            // A read already on the bus is finished off and its data dropped.
            page_nx_s  = map_page(src_page);
            index_nx_s = 8'd0;
            delay_nx_s = 8'd0;
            state_nx_s = DELAY;
            busy_nx_s  = 1'b1;
            stb_nx_s   = stb_r & rd_stall;
            cyc_nx_s   = cyc_r & ~ack_ok_s;
            drain_nx_s = cyc_r & ~ack_ok_s;
        end else begin
            if (drain_r) begin
                stb_nx_s   = stb_r & rd_stall;
                cyc_nx_s   = cyc_r & ~ack_ok_s;
                drain_nx_s = cyc_r & ~ack_ok_s;
            end else begin
                drain_nx_s = 1'b0;
            end

            case (state_r)
                IDLE: begin
                    state_nx_s = IDLE;
                end
                DELAY: begin
                    if (m_tick && (delay_r != DELAY_TICKS)) begin
                        delay_step_s = delay_r + 8'd1;
                    end else begin
                        delay_step_s = delay_r;
                    end
                    delay_nx_s = delay_step_s;
                    if ((delay_step_s == DELAY_TICKS) && !drain_nx_s) begin
                        state_nx_s = ISSUE;
                    end else begin
                        state_nx_s = DELAY;
                    end
                end
                ISSUE: begin
                    if (!stb_r) begin
                        if (m_tick) begin
                            cyc_nx_s  = 1'b1;
                            stb_nx_s  = 1'b1;
                            addr_nx_s = {page_r, index_r};
                        end else begin
                            state_nx_s = ISSUE;
                        end
                    end else if (!rd_stall) begin
                        stb_nx_s = 1'b0;
                        if (rd_ack) begin
                            cyc_nx_s      = 1'b0;
                            we_nx_s       = 1'b1;
                            oam_addr_nx_s = index_r;
                            oam_dat_nx_s  = rd_dat;
                            state_nx_s    = WRITE;
                        end else begin
                            state_nx_s = WAIT;
                        end
                    end else begin
                        state_nx_s = ISSUE;
                    end
                end
                WAIT: begin
                    if (rd_ack) begin
                        cyc_nx_s      = 1'b0;
                        we_nx_s       = 1'b1;
                        oam_addr_nx_s = index_r;
                        oam_dat_nx_s  = rd_dat;
                        state_nx_s    = WRITE;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end
                WRITE: begin
                    if (index_r == LAST_INDEX) begin
                        index_nx_s = 8'd0;
                        busy_nx_s  = 1'b0;
                        state_nx_s = IDLE;
                    end else begin
                        index_nx_s = index_r + 8'd1;
                        state_nx_s = ISSUE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    busy_nx_s  = 1'b0;
                    cyc_nx_s   = 1'b0;
                    stb_nx_s   = 1'b0;
                    drain_nx_s = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            index_r    <= 8'd0;
            page_r     <= 8'd0;
            delay_r    <= 8'd0;
            drain_r    <= 1'b0;
            busy_r     <= 1'b0;
            cyc_r      <= 1'b0;
            stb_r      <= 1'b0;
            addr_r     <= 16'd0;
            we_r       <= 1'b0;
            oam_addr_r <= 8'd0;
            oam_dat_r  <= 8'd0;
        end else begin
            state_r    <= state_nx_s;
            index_r    <= index_nx_s;
            page_r     <= page_nx_s;
            delay_r    <= delay_nx_s;
            drain_r    <= drain_nx_s;
            busy_r     <= busy_nx_s;
            cyc_r      <= cyc_nx_s;
            stb_r      <= stb_nx_s;
            addr_r     <= addr_nx_s;
            we_r       <= we_nx_s;
            oam_addr_r <= oam_addr_nx_s;
            oam_dat_r  <= oam_dat_nx_s;
        end
    end

    assign busy      = busy_r;
    assign cpu_block = busy_r;
    assign rd_cyc    = cyc_r;
    assign rd_stb    = stb_r;
    assign rd_addr   = addr_r;
    assign oam_we    = we_r;
    assign oam_addr  = oam_addr_r;
    assign oam_dat   = oam_dat_r;

endmodule
